spi_controller: RTL

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : spi_controller
//  Description : Mode-0 SPI master issuing 16-bit frames
//                {write, addr[6:0], wdata[7:0]} MSB first. The final receive
//                byte of each frame is presented on rd_data with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       CIPO,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data
);

    // Half-period counter sized to hold CLK_DIV.
    localparam int                 c_DIV_W      = $clog2(CLK_DIV + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE    = c_DIV_W'(1);
    localparam logic [3:0]         c_SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0]         c_HOLD_LAST  = 4'(CS_HOLD - 1);
    localparam logic [3:0]         c_GAP_LAST   = 4'(IDLE_GAP - 1);
    localparam logic [4:0]         c_LAST_BIT   = 5'd15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ncs;
    logic                 r_sclk;
    logic [15:0]          r_tx;
    logic [15:0]          r_rx;
    logic [7:0]           r_rd_data;
    logic [c_DIV_W-1:0]   r_div;
    logic [4:0]           r_bit;
    logic [3:0]           r_cnt;

    // The upper receive byte echoes the command phase; only the data byte
    // is exported, so its top bit is intentionally left unread.
    logic                 w_rx_unused;
    assign w_rx_unused = r_rx[15];

    // Frame sequencer: all SPI pins and handshake outputs are registered here.
    // COPI is taken straight from the top of the transmit shifter, which is
    // cleared whenever nCS is high so COPI idles low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ncs     <= 1'b1;
            r_sclk    <= 1'b0;
            r_tx      <= 16'h0000;
            r_rx      <= 16'h0000;
            r_rd_data <= 8'h00;
            r_div     <= '0;
            r_bit     <= 5'd0;
            r_cnt     <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_tx    <= {req_write, req_addr, req_wdata};
                        r_rx    <= 16'h0000;
                        r_ncs   <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == c_SETUP_LAST) begin
                        r_cnt   <= 4'd0;
                        r_div   <= '0;
                        r_bit   <= 5'd0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            // Rising edge: capture the peripheral bit.
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[14:0], CIPO};
                        end else begin
                            // Falling edge: present the next lower bit.
                            r_sclk <= 1'b0;
                            r_tx   <= {r_tx[14:0], 1'b0};
                            if (r_bit == c_LAST_BIT) begin
                                r_bit   <= 5'd0;
                                r_cnt   <= 4'd0;
                                r_state <= S_HOLD;
                            end else begin
                                r_bit <= r_bit + 5'd1;
                            end
                        end
                    end else begin
                        r_div <= r_div + c_DIV_ONE;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_cnt     <= 4'd0;
                        r_ncs     <= 1'b1;
                        r_tx      <= 16'h0000;
                        r_rd_data <= r_rx[7:0];
                        r_done    <= 1'b1;
                        r_state   <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= 4'd0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ncs   <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_tx    <= 16'h0000;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign nCS       = r_ncs;
    assign SCLK      = r_sclk;
    assign COPI      = r_tx[15];
    assign rd_data   = r_rd_data;

endmodule
`default_nettype wire
